// File: rtl/mult_pipe_ext_if.sv
// Request/response bundle of the pipelined multiplier: issue side (in_*) and
// CDB side (out_*), each with its own valid/ready pair.
interface mult_pipe_ext_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

// File: rtl/mult_pipe_ext.sv
// Stallable, flushable, NUM_STAGE-deep sign-magnitude multiplier covering
// MUL/MULH/MULHSU/MULHU; each stage retires XLEN/NUM_STAGE multiplier bits.
module mult_pipe_ext #(
    parameter int XLEN      = 64,
    parameter int NUM_STAGE = 8,
    parameter int TAG_W     = 6
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            flush,
    output logic            busy,
    mult_pipe_ext_if.slave  bus
);
    localparam int M  = XLEN / NUM_STAGE;
    localparam int PW = 2 * XLEN;

    logic [NUM_STAGE-1:0]             valid_q, valid_d;
    logic [NUM_STAGE-1:0]             neg_q, neg_d;
    logic [NUM_STAGE-1:0][1:0]        op_q, op_d;
    logic [NUM_STAGE-1:0][TAG_W-1:0]  tag_q, tag_d;
    logic [NUM_STAGE-1:0][PW-1:0]     mcand_q, mcand_d;
    logic [NUM_STAGE-1:0][PW-1:0]     sum_q, sum_d;
    logic [NUM_STAGE-1:0][XLEN-1:0]   mplier_q, mplier_d;

    logic            sign_a, sign_b, stall, unused_tail;
    logic [XLEN-1:0] a_mag, b_mag;

    function automatic logic [PW-1:0] step_sum(input logic [PW-1:0] sum,
                                               input logic [PW-1:0] mcand,
                                               input logic [M-1:0]  digit);
        logic [PW-1:0] digit_ext;
        digit_ext = {{(PW-M){1'b0}}, digit};
        return sum + mcand * digit_ext;
    endfunction

    // Negating the full 2*XLEN sum keeps MUL's low half equal to the unsigned product.
    function automatic logic [XLEN-1:0] final_result(input logic [PW-1:0] sum,
                                                     input logic          neg,
                                                     input logic [1:0]    op);
        logic [PW-1:0] full;
        full = neg ? -sum : sum;
        return (op == 2'b00) ? full[XLEN-1:0] : full[PW-1:XLEN];
    endfunction

    assign sign_a = (bus.in_op != 2'b11) && bus.in_a[XLEN-1];
    assign sign_b = !bus.in_op[1] && bus.in_b[XLEN-1];
    assign a_mag  = sign_a ? -bus.in_a : bus.in_a;
    assign b_mag  = sign_b ? -bus.in_b : bus.in_b;

    assign stall        = valid_q[NUM_STAGE-1] && !bus.out_ready;
    assign bus.in_ready = !stall;

    always_comb begin
        valid_d[0]  = bus.in_valid;
        op_d[0]     = bus.in_op;
        tag_d[0]    = bus.in_tag;
        neg_d[0]    = sign_a ^ sign_b;
        sum_d[0]    = step_sum('0, {{XLEN{1'b0}}, a_mag}, b_mag[M-1:0]);
        mcand_d[0]  = {{XLEN{1'b0}}, a_mag} << M;
        mplier_d[0] = b_mag >> M;
        for (int s = 1; s < NUM_STAGE; s++) begin
            valid_d[s]  = valid_q[s-1];
            op_d[s]     = op_q[s-1];
            tag_d[s]    = tag_q[s-1];
            neg_d[s]    = neg_q[s-1];
            sum_d[s]    = step_sum(sum_q[s-1], mcand_q[s-1], mplier_q[s-1][M-1:0]);
            mcand_d[s]  = mcand_q[s-1] << M;
            mplier_d[s] = mplier_q[s-1] >> M;
        end
    end

    // Control: flush wins over stall; a stalled pipe holds every valid bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
        end else if (flush) begin
            valid_q <= '0;
        end else if (!stall) begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!stall) begin
            op_q     <= op_d;
            tag_q    <= tag_d;
            neg_q    <= neg_d;
            sum_q    <= sum_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

    // Outputs are gated by the final valid so reset shows zeros without resetting data.
    assign bus.out_valid  = valid_q[NUM_STAGE-1];
    assign bus.out_result = valid_q[NUM_STAGE-1]
                          ? final_result(sum_q[NUM_STAGE-1], neg_q[NUM_STAGE-1], op_q[NUM_STAGE-1])
                          : '0;
    assign bus.out_tag    = valid_q[NUM_STAGE-1] ? tag_q[NUM_STAGE-1] : '0;
    assign busy           = |valid_q;

    assign unused_tail = ^{mcand_q[NUM_STAGE-1], mplier_q[NUM_STAGE-1]};
endmodule

// File: tb/tb_mult_pipe_ext.sv
// Bench for mult_pipe_ext: directed vectors on a 64/8 instance, 32/4 and 32/1
// instances in parallel, then random traffic against a wide-arithmetic model.
module tb_mult_pipe_ext;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic flush = 1'b0;
    logic busy_a, busy_b, busy_c;
    int   n_chk = 0;
    int   n_pass = 0;
    bit   sb_on = 1'b0;
    logic [69:0] qa[$], qb[$], qc[$];

    always #5 clock = ~clock;

    mult_pipe_ext_if #(.XLEN(64), .TAG_W(6)) ifa ();
    mult_pipe_ext_if #(.XLEN(32), .TAG_W(6)) ifb ();
    mult_pipe_ext_if #(.XLEN(32), .TAG_W(6)) ifc ();

    mult_pipe_ext #(.XLEN(64), .NUM_STAGE(8), .TAG_W(6)) dut_a (
        .clock(clock), .reset_n(reset_n), .flush(flush), .busy(busy_a), .bus(ifa.slave));
    mult_pipe_ext #(.XLEN(32), .NUM_STAGE(4), .TAG_W(6)) dut_b (
        .clock(clock), .reset_n(reset_n), .flush(flush), .busy(busy_b), .bus(ifb.slave));
    mult_pipe_ext #(.XLEN(32), .NUM_STAGE(1), .TAG_W(6)) dut_c (
        .clock(clock), .reset_n(reset_n), .flush(flush), .busy(busy_c), .bus(ifc.slave));

    typedef struct {
        logic [1:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [5:0]  tag;
        logic [63:0] exp;
    } vec_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec32_t;

    task automatic chk(input string nm, input logic [69:0] got, input logic [69:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    task automatic fail_now(input string nm);
        n_chk++;
        $display("FAIL %s: result with no outstanding request", nm);
    endtask

    // Reference via signed 130-bit arithmetic on sign- or zero-extended operands.
    function automatic logic [63:0] ref_mul(input int w, input logic [1:0] op,
                                            input logic [63:0] a, input logic [63:0] b);
        logic signed [129:0] ax, bx, p, m;
        m  = (130'sd1 <<< w) - 130'sd1;
        ax = {66'd0, a} & m;
        bx = {66'd0, b} & m;
        if (op != 2'b11 && a[w-1]) ax = ax - (130'sd1 <<< w);
        if (!op[1] && b[w-1])      bx = bx - (130'sd1 <<< w);
        p = ax * bx;
        p = (op == 2'b00) ? (p & m) : ((p >>> w) & m);
        return p[63:0];
    endfunction

    function automatic logic [63:0] pick();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'h8000_0000_8000_0000;
            2:       return '1;
            3:       return 64'($urandom_range(0, 15));
            4:       return {1'b1, 31'($urandom), 1'b1, 31'($urandom)};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Called just after a rising edge; returns just after a rising edge.
    task automatic run_a(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [5:0] tag, output logic [63:0] res,
                         output logic [5:0] tg, output int lat);
        ifa.in_valid = 1'b1; ifa.in_op = op; ifa.in_a = a; ifa.in_b = b; ifa.in_tag = tag;
        ifa.out_ready = 1'b1;
        @(posedge clock); #1;
        ifa.in_valid = 1'b0;
        lat = 1;
        @(negedge clock);
        while (!ifa.out_valid && lat < 40) begin
            @(negedge clock);
            lat++;
        end
        res = ifa.out_result;
        tg  = ifa.out_tag;
        @(posedge clock); #1;
    endtask

    task automatic run_32(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [5:0] tag, output logic [31:0] rb,
                          output logic [31:0] rc, output int lb, output int lc);
        ifb.in_valid = 1'b1; ifb.in_op = op; ifb.in_a = a; ifb.in_b = b; ifb.in_tag = tag;
        ifc.in_valid = 1'b1; ifc.in_op = op; ifc.in_a = a; ifc.in_b = b; ifc.in_tag = tag;
        ifb.out_ready = 1'b1; ifc.out_ready = 1'b1;
        @(posedge clock); #1;
        ifb.in_valid = 1'b0; ifc.in_valid = 1'b0;
        lb = 0; lc = 0; rb = '0; rc = '0;
        for (int n = 1; n <= 20 && (lb == 0 || lc == 0); n++) begin
            @(negedge clock);
            if (lb == 0 && ifb.out_valid) begin lb = n; rb = ifb.out_result; end
            if (lc == 0 && ifc.out_valid) begin lc = n; rc = ifc.out_result; end
        end
        @(posedge clock); #1;
    endtask

    always @(negedge clock) begin
        if (sb_on) begin
            if (ifa.out_valid && ifa.out_ready) begin
                if (qa.size() == 0) fail_now("rand_a_spurious");
                else chk("rand_a", {ifa.out_tag, ifa.out_result}, qa.pop_front());
            end
            if (ifa.in_valid && ifa.in_ready)
                qa.push_back({ifa.in_tag, ref_mul(64, ifa.in_op, ifa.in_a, ifa.in_b)});
            if (ifb.out_valid && ifb.out_ready) begin
                if (qb.size() == 0) fail_now("rand_b_spurious");
                else chk("rand_b", {ifb.out_tag, 32'd0, ifb.out_result}, qb.pop_front());
            end
            if (ifb.in_valid && ifb.in_ready)
                qb.push_back({ifb.in_tag, ref_mul(32, ifb.in_op, {32'd0, ifb.in_a}, {32'd0, ifb.in_b})});
            if (ifc.out_valid && ifc.out_ready) begin
                if (qc.size() == 0) fail_now("rand_c_spurious");
                else chk("rand_c", {ifc.out_tag, 32'd0, ifc.out_result}, qc.pop_front());
            end
            if (ifc.in_valid && ifc.in_ready)
                qc.push_back({ifc.in_tag, ref_mul(32, ifc.in_op, {32'd0, ifc.in_a}, {32'd0, ifc.in_b})});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        va[9];
        vec32_t      vb[5];
        logic [63:0] res;
        logic [5:0]  tg;
        logic [31:0] rb, rc;
        int          lat, lb, lc, idx, exp_t, hold, seen_cnt;
        bit          seen, acc, ret;
        logic [1:0]  op;
        logic [63:0] ra, rbv;

        va[0] = '{2'b00, 64'd3, 64'd5, 6'h2A, 64'd15};
        va[1] = '{2'b00, '1, '1, 6'h01, 64'd1};
        va[2] = '{2'b01, '1, '1, 6'h02, 64'd0};
        va[3] = '{2'b11, '1, '1, 6'h03, 64'hFFFF_FFFF_FFFF_FFFE};
        va[4] = '{2'b10, '1, 64'd2, 6'h04, 64'hFFFF_FFFF_FFFF_FFFF};
        va[5] = '{2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 6'h05, 64'h4000_0000_0000_0000};
        va[6] = '{2'b01, 64'd0, '1, 6'h06, 64'd0};
        va[7] = '{2'b00, 64'hFFFF_FFFF_FFFF_FFF9, 64'd6, 6'h07, 64'hFFFF_FFFF_FFFF_FFD6};
        va[8] = '{2'b10, 64'd2, '1, 6'h08, 64'd1};

        vb[0] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vb[1] = '{2'b00, 32'h1234_5678, 32'h10, 32'h2345_6780};
        vb[2] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vb[3] = '{2'b10, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF};
        vb[4] = '{2'b00, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6};

        ifa.in_valid = 0; ifa.in_op = 0; ifa.in_a = 0; ifa.in_b = 0; ifa.in_tag = 0; ifa.out_ready = 1;
        ifb.in_valid = 0; ifb.in_op = 0; ifb.in_a = 0; ifb.in_b = 0; ifb.in_tag = 0; ifb.out_ready = 1;
        ifc.in_valid = 0; ifc.in_op = 0; ifc.in_a = 0; ifc.in_b = 0; ifc.in_tag = 0; ifc.out_ready = 1;

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_out_valid", 70'(ifa.out_valid), 70'(0));
        chk("reset_busy", 70'(busy_a), 70'(0));
        chk("reset_result", 70'(ifa.out_result), 70'(0));
        chk("reset_tag", 70'(ifa.out_tag), 70'(0));
        chk("reset_in_ready", 70'(ifa.in_ready), 70'(1));
        @(posedge clock); #1;
        reset_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_a(va[i].op, va[i].a, va[i].b, va[i].tag, res, tg, lat);
            chk($sformatf("vec%0d_result", i), 70'(res), 70'(va[i].exp));
            chk($sformatf("vec%0d_tag", i), 70'(tg), 70'(va[i].tag));
            chk($sformatf("vec%0d_latency", i), 70'(lat), 70'(8));
        end

        // Back-pressure: ten ops, consumer stalls for three cycles at the first result.
        idx = 0; exp_t = 0; hold = 0; seen = 0;
        ifa.in_valid = 1; ifa.in_op = 2'b00; ifa.in_a = 64'd2; ifa.in_b = 64'd7; ifa.in_tag = 6'd0;
        for (int cyc = 0; cyc < 80 && exp_t < 10; cyc++) begin
            if (ifa.out_valid && !seen) begin seen = 1; ifa.out_ready = 0; end
            @(negedge clock);
            acc = ifa.in_valid && ifa.in_ready;
            ret = ifa.out_valid && ifa.out_ready;
            if (seen && !ifa.out_ready) begin
                if (hold == 0) chk("bp_in_ready_low", 70'(ifa.in_ready), 70'(0));
                chk("bp_hold_tag", 70'(ifa.out_tag), 70'(0));
                chk("bp_hold_result", 70'(ifa.out_result), 70'(14));
            end
            if (ret) begin
                chk("bp_tag_order", 70'(ifa.out_tag), 70'(exp_t));
                chk("bp_result", 70'(ifa.out_result), 70'((exp_t + 2) * (exp_t + 7)));
                exp_t++;
            end
            @(posedge clock); #1;
            if (acc) begin
                idx++;
                if (idx < 10) begin
                    ifa.in_a = 64'(idx + 2); ifa.in_b = 64'(idx + 7); ifa.in_tag = 6'(idx);
                end else ifa.in_valid = 0;
            end
            if (seen && !ifa.out_ready) begin
                hold++;
                if (hold == 3) ifa.out_ready = 1;
            end
        end
        chk("bp_count", 70'(exp_t), 70'(10));
        @(negedge clock);
        chk("bp_busy_idle", 70'(busy_a), 70'(0));
        @(posedge clock); #1;

        // Flush with four ops in flight and a concurrent request.
        for (int i = 0; i < 4; i++) begin
            ifa.in_valid = 1; ifa.in_op = 2'b00; ifa.in_a = 64'(i + 1); ifa.in_b = 64'd3; ifa.in_tag = 6'(10 + i);
            @(posedge clock); #1;
        end
        ifa.in_tag = 6'h3F; flush = 1;
        @(negedge clock);
        chk("flush_busy_before", 70'(busy_a), 70'(1));
        @(posedge clock); #1;
        flush = 0; ifa.in_valid = 0;
        @(negedge clock);
        chk("flush_out_valid", 70'(ifa.out_valid), 70'(0));
        chk("flush_busy_after", 70'(busy_a), 70'(0));
        seen_cnt = 0;
        repeat (12) begin
            @(negedge clock);
            if (ifa.out_valid) seen_cnt++;
        end
        chk("flush_no_output", 70'(seen_cnt), 70'(0));
        @(posedge clock); #1;
        run_a(2'b11, '1, 64'd3, 6'h15, res, tg, lat);
        chk("post_flush_result", 70'(res), 70'(2));
        chk("post_flush_tag", 70'(tg), 70'(6'h15));
        chk("post_flush_latency", 70'(lat), 70'(8));

        // Asynchronous reset with the pipeline full and a result presented.
        for (int i = 0; i < 8; i++) begin
            ifa.in_valid = 1; ifa.in_op = 2'b00; ifa.in_a = 64'(i + 5); ifa.in_b = 64'(i); ifa.in_tag = 6'(20 + i);
            @(posedge clock); #1;
        end
        ifa.in_valid = 0;
        chk("rst_pre_out_valid", 70'(ifa.out_valid), 70'(1));
        #2 reset_n = 0;
        #1;
        chk("rst_async_out_valid", 70'(ifa.out_valid), 70'(0));
        chk("rst_async_busy", 70'(busy_a), 70'(0));
        chk("rst_async_result", 70'(ifa.out_result), 70'(0));
        chk("rst_async_tag", 70'(ifa.out_tag), 70'(0));
        chk("rst_async_in_ready", 70'(ifa.in_ready), 70'(1));
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset_n = 1;
        seen_cnt = 0;
        repeat (12) begin
            @(negedge clock);
            if (ifa.out_valid) seen_cnt++;
        end
        chk("rst_no_stale", 70'(seen_cnt), 70'(0));
        @(posedge clock); #1;
        run_a(2'b00, 64'h1234_5678, 64'h10, 6'h33, res, tg, lat);
        chk("post_rst_result", 70'(res), 70'(64'h1_2345_6780));
        chk("post_rst_latency", 70'(lat), 70'(8));

        // 32-bit instances, four-stage and single-stage, side by side.
        for (int i = 0; i < 5; i++) begin
            run_32(vb[i].op, vb[i].a, vb[i].b, 6'(i), rb, rc, lb, lc);
            chk($sformatf("x32s4_vec%0d_result", i), 70'(rb), 70'(vb[i].exp));
            chk($sformatf("x32s1_vec%0d_result", i), 70'(rc), 70'(vb[i].exp));
            chk($sformatf("x32s4_vec%0d_latency", i), 70'(lb), 70'(4));
            chk($sformatf("x32s1_vec%0d_latency", i), 70'(lc), 70'(1));
        end

        // Random traffic with random back-pressure on all three instances.
        sb_on = 1;
        for (int cyc = 0; cyc < 12000; cyc++) begin
            op = 2'($urandom_range(0, 3));
            ra = pick(); rbv = pick();
            ifa.in_op = op; ifa.in_a = ra; ifa.in_b = rbv; ifa.in_tag = 6'($urandom_range(0, 63));
            ifb.in_op = op; ifb.in_a = ra[31:0]; ifb.in_b = rbv[31:0]; ifb.in_tag = ifa.in_tag;
            ifc.in_op = op; ifc.in_a = ra[31:0]; ifc.in_b = rbv[31:0]; ifc.in_tag = ifa.in_tag;
            ifa.in_valid = ($urandom_range(0, 3) != 0);
            ifb.in_valid = ifa.in_valid; ifc.in_valid = ifa.in_valid;
            ifa.out_ready = ($urandom_range(0, 3) != 0);
            ifb.out_ready = ifa.out_ready; ifc.out_ready = ifa.out_ready;
            @(posedge clock); #1;
        end
        ifa.in_valid = 0; ifb.in_valid = 0; ifc.in_valid = 0;
        ifa.out_ready = 1; ifb.out_ready = 1; ifc.out_ready = 1;
        repeat (30) @(posedge clock);
        #1;
        sb_on = 0;
        chk("rand_a_drained", 70'(qa.size()), 70'(0));
        chk("rand_b_drained", 70'(qb.size()), 70'(0));
        chk("rand_c_drained", 70'(qc.size()), 70'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
